// File: rtl/instruction_fetch.sv
// Two-state instruction fetch unit: issues word reads to instruction memory,
// presents one fetched word at a time to decode, and handles PC redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out
);

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] STEP      = 32'(PC_STEP);

    typedef enum logic {
        FETCH,
        DELIVER
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        imem_read_q, imem_read_d;
    logic [31:0] instruction_q, instruction_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        flush_q, flush_d;

    logic [31:0] target;
    logic [31:0] redirect;
    logic        complete;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_addr_d   = imem_addr_q;
        imem_read_d   = imem_read_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        flush_d       = flush_q;

        target   = branch_target & ADDR_MASK;
        redirect = branch_en ? target : pc_q;
        complete = imem_read_q && !imem_busy;

        case (state_q)
            FETCH: begin
                if (!imem_read_q) begin
                    // Request not yet launched (first cycle after reset): a redirect
                    // can still retarget it without violating address stability.
                    if (branch_en) begin
                        pc_d        = target;
                        imem_addr_d = target;
                    end
                    imem_read_d = 1'b1;
                end else if (complete) begin
                    if (flush_q || branch_en) begin
                        pc_d        = redirect & ADDR_MASK;
                        imem_addr_d = redirect & ADDR_MASK;
                        imem_read_d = 1'b1;
                        flush_d     = 1'b0;
                    end else begin
                        instruction_d = imem_rdata;
                        pc_out_d      = imem_addr_q;
                        instr_valid_d = 1'b1;
                        pc_d          = (imem_addr_q + STEP) & ADDR_MASK;
                        imem_read_d   = 1'b0;
                        state_d       = DELIVER;
                    end
                end else if (branch_en) begin
                    // Access in flight: remember the target, drop the data on completion.
                    pc_d    = target;
                    flush_d = 1'b1;
                end
            end

            DELIVER: begin
                if (branch_en) begin
                    instr_valid_d = 1'b0;
                    pc_d          = target;
                    imem_addr_d   = target;
                    imem_read_d   = 1'b1;
                    state_d       = FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    imem_addr_d   = pc_q & ADDR_MASK;
                    imem_read_d   = 1'b1;
                    state_d       = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            pc_q          <= (RESET_PC + STEP) & ADDR_MASK;
            imem_addr_q   <= RESET_PC & ADDR_MASK;
            imem_read_q   <= 1'b0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            imem_read_q   <= imem_read_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
            flush_q       <= flush_d;
        end
    end

    assign imem_addr   = imem_addr_q;
    assign imem_read   = imem_read_q;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; memory returns 0x100|addr.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h0000_0100 | imem_addr;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_read    (imem_read),
        .imem_busy    (imem_busy),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out)
    );

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Leaves the DUT in FETCH with the RESET_PC request on the bus.
    task automatic apply_reset;
        reset = 1'b0; imem_busy = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset;
        reset = 1'b0; imem_busy = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
        step();
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%0b exp=0", imem_read); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
        reset = 1'b1;
        step();
        checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL release_read got=%0b exp=1", imem_read); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL release_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] a;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            a = 32'(k * 4);
            step();
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%0b exp=1", k, instr_valid); end
            checks++; if (instruction !== (32'h100 | a)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, instruction, 32'h100 | a); end
            checks++; if (pc_out !== a) begin failures++; $display("FAIL stream_pc_out[%0d] got=%h exp=%h", k, pc_out, a); end
            checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL stream_read_lo[%0d] got=%0b exp=0", k, imem_read); end
            step();
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_consumed[%0d] got=%0b exp=0", k, instr_valid); end
            checks++; if (imem_read !== 1'b1 || imem_addr !== a + 32'd4) begin failures++; $display("FAIL stream_next_req[%0d] got=%0b/%h exp=1/%h", k, imem_read, imem_addr, a + 32'd4); end
        end
    endtask

    task automatic test_wait_states;
        apply_reset();
        step();
        step();
        checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL wait_first got=%0b/%h exp=1/00000004", imem_read, imem_addr); end
        imem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
                failures++; $display("FAIL wait_hold[%0d] got=%0b/%h/%0b exp=1/00000004/0", k, imem_read, imem_addr, instr_valid);
            end
        end
        imem_busy = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h104 || pc_out !== 32'h4) begin
            failures++; $display("FAIL wait_deliver got=%0b/%h/%h exp=1/00000104/00000004", instr_valid, instruction, pc_out);
        end
        step();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8 || imem_read !== 1'b1) begin
            failures++; $display("FAIL wait_once got=%0b/%h/%0b exp=0/00000008/1", instr_valid, imem_addr, imem_read);
        end
    endtask

    task automatic test_stall;
        apply_reset();
        step();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instruction !== 32'h100 || pc_out !== 32'h0 || imem_read !== 1'b0) begin
                failures++; $display("FAIL stall_hold[%0d] got=%0b/%h/%h/%0b exp=1/00000100/00000000/0", k, instr_valid, instruction, pc_out, imem_read);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h4) begin
            failures++; $display("FAIL stall_release got=%0b/%0b/%h exp=0/1/00000004", instr_valid, imem_read, imem_addr);
        end
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h104 || pc_out !== 32'h4) begin
            failures++; $display("FAIL stall_next got=%0b/%h/%h exp=1/00000104/00000004", instr_valid, instruction, pc_out);
        end
    endtask

    task automatic test_branch_flush;
        apply_reset();
        step(); step(); step(); step();
        checks++; if (imem_addr !== 32'h8 || imem_read !== 1'b1) begin failures++; $display("FAIL flush_setup got=%h/%0b exp=00000008/1", imem_addr, imem_read); end
        imem_busy = 1'b1;
        step();
        branch_en = 1'b1; branch_target = 32'h43;
        step();
        branch_en = 1'b0;
        checks++; if (imem_addr !== 32'h8 || imem_read !== 1'b1 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL flush_inflight got=%h/%0b/%0b exp=00000008/1/0", imem_addr, imem_read, instr_valid);
        end
        step();
        checks++; if (imem_addr !== 32'h8 || instr_valid !== 1'b0) begin failures++; $display("FAIL flush_hold got=%h/%0b exp=00000008/0", imem_addr, instr_valid); end
        imem_busy = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h40) begin
            failures++; $display("FAIL flush_discard got=%0b/%0b/%h exp=0/1/00000040", instr_valid, imem_read, imem_addr);
        end
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h140 || pc_out !== 32'h40) begin
            failures++; $display("FAIL flush_target got=%0b/%h/%h exp=1/00000140/00000040", instr_valid, instruction, pc_out);
        end
    endtask

    task automatic test_last_wins;
        apply_reset();
        step(); step();
        imem_busy = 1'b1;
        step();
        branch_en = 1'b1; branch_target = 32'h40;
        step();
        branch_target = 32'h61;
        step();
        branch_en = 1'b0; imem_busy = 1'b0;
        checks++; if (imem_addr !== 32'h4 || instr_valid !== 1'b0) begin failures++; $display("FAIL last_inflight got=%h/%0b exp=00000004/0", imem_addr, instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h60) begin
            failures++; $display("FAIL last_redirect got=%0b/%0b/%h exp=0/1/00000060", instr_valid, imem_read, imem_addr);
        end
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h160 || pc_out !== 32'h60) begin
            failures++; $display("FAIL last_deliver got=%0b/%h/%h exp=1/00000160/00000060", instr_valid, instruction, pc_out);
        end
    endtask

    task automatic test_branch_deliver_complete;
        apply_reset();
        step();
        stall = 1'b1; branch_en = 1'b1; branch_target = 32'h22;
        step();
        stall = 1'b0; branch_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h20) begin
            failures++; $display("FAIL bdel_redirect got=%0b/%0b/%h exp=0/1/00000020", instr_valid, imem_read, imem_addr);
        end
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h120 || pc_out !== 32'h20) begin
            failures++; $display("FAIL bdel_deliver got=%0b/%h/%h exp=1/00000120/00000020", instr_valid, instruction, pc_out);
        end
        step();
        checks++; if (imem_addr !== 32'h24 || imem_read !== 1'b1) begin failures++; $display("FAIL bcmp_setup got=%h/%0b exp=00000024/1", imem_addr, imem_read); end
        branch_en = 1'b1; branch_target = 32'h80;
        step();
        branch_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h80) begin
            failures++; $display("FAIL bcmp_discard got=%0b/%0b/%h exp=0/1/00000080", instr_valid, imem_read, imem_addr);
        end
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h180 || pc_out !== 32'h80) begin
            failures++; $display("FAIL bcmp_deliver got=%0b/%h/%h exp=1/00000180/00000080", instr_valid, instruction, pc_out);
        end
    endtask

    task automatic test_wrap_reset;
        apply_reset();
        step();
        branch_en = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_en = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_read !== 1'b1) begin failures++; $display("FAIL wrap_req got=%h/%0b exp=fffffffc/1", imem_addr, imem_read); end
        step();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instruction !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_deliver got=%0b/%h/%h exp=1/fffffffc/fffffffc", instr_valid, pc_out, instruction);
        end
        step();
        checks++; if (imem_addr !== 32'h0 || imem_read !== 1'b1) begin failures++; $display("FAIL wrap_next got=%h/%0b exp=00000000/1", imem_addr, imem_read); end
        imem_busy = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (imem_read !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0) begin
            failures++; $display("FAIL midreset got=%0b/%0b/%h exp=0/0/00000000", imem_read, instr_valid, instruction);
        end
        reset = 1'b1; imem_busy = 1'b0;
        step();
        checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL midreset_restart got=%0b/%h exp=1/00000000", imem_read, imem_addr); end
        step();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h100 || pc_out !== 32'h0) begin
            failures++; $display("FAIL midreset_first got=%0b/%h/%h exp=1/00000100/00000000", instr_valid, instruction, pc_out);
        end
    endtask

    initial begin
        reset = 1'b0; imem_busy = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_branch_flush();
        test_last_wins();
        test_branch_deliver_complete();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
